// File: rtl/mem_rr_arbiter.sv
// Four-requester round-robin arbiter for a shared memory/bus port.
// Drives the owner one-hot grant, the binary mux select and the port valid
// strobe. Ownership lasts until the port acknowledges or the watchdog
// expires. After either release the next owner is granted in the same cycle.
module mem_rr_arbiter #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mem_ready,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       mem_valid,
    output logic       timeout_err,
    output logic [1:0] last_owner
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Count value of the last cycle a grant may wait before forced release.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam bit                   WDOG_EN  = (TIMEOUT != 0);

    state_t               state, state_nxt;
    logic [3:0]           grant_nxt;
    logic [1:0]           sel_nxt;
    logic                 timeout_nxt;
    logic [1:0]           last_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

    // {found, index} results of the two arbitration searches
    logic [2:0]           idle_pick;
    logic [2:0]           rel_pick;
    logic                 expired;

    // Round-robin search: first set bit of r starting at ptr+1, wrapping.
    // Candidates are visited farthest first, so the nearest one wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // From IDLE the search starts after the last released owner. On release
    // the owner's own bit is masked, because it is still asserting req during
    // its completion cycle.
    assign idle_pick = rr_pick(req, last_owner);
    assign rel_pick  = rr_pick(req & ~grant, sel);
    assign expired   = WDOG_EN && !mem_ready && (cnt == CNT_LAST);
    assign mem_valid = |grant;

    // Next-state and registered-output decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        grant_nxt   = grant;
        sel_nxt     = sel;
        last_nxt    = last_owner;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (idle_pick[2]) begin
                    state_nxt = BUSY;
                    grant_nxt = 4'b0001 << idle_pick[1:0];
                    sel_nxt   = idle_pick[1:0];
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (mem_ready || expired) begin
                    last_nxt    = sel;
                    timeout_nxt = expired;
                    if (rel_pick[2]) begin
                        grant_nxt = 4'b0001 << rel_pick[1:0];
                        sel_nxt   = rel_pick[1:0];
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 4'b0000;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            sel         <= 2'd0;
            timeout_err <= 1'b0;
            last_owner  <= 2'd3;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            sel         <= sel_nxt;
            timeout_err <= timeout_nxt;
            last_owner  <= last_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter (watchdog set to 4 cycles).
// Each step drives inputs on the falling edge and queues the outputs expected
// after the next rising edge. A monitor pops and compares just after that edge.
module tb_mem_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       mem_ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_valid;
    logic       timeout_err;
    logic [1:0] last_owner;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] g;
        logic [1:0] s;
        logic       te;
        logic [1:0] lo;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    mem_rr_arbiter #(
        .TIMEOUT   (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mem_ready   (mem_ready),
        .grant       (grant),
        .sel         (sel),
        .mem_valid   (mem_valid),
        .timeout_err (timeout_err),
        .last_owner  (last_owner)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string tag, input logic r, input logic [3:0] q,
                                input logic rdy, input logic [3:0] g, input logic [1:0] s,
                                input logic te, input logic [1:0] lo);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.req = q; v.rdy = rdy;
        v.g = g; v.s = s; v.te = te; v.lo = lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst_n     = v.rst_n;
        req       = v.req;
        mem_ready = v.rdy;
        sb.push_back(v);
    endtask

    // Scoreboard monitor: compares the outputs produced by each queued step.
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " grant"},       grant,                 e.g);
            check({e.tag, " sel"},         {2'b00, sel},          {2'b00, e.s});
            check({e.tag, " mem_valid"},   {3'b000, mem_valid},   {3'b000, |e.g});
            check({e.tag, " timeout_err"}, {3'b000, timeout_err}, {3'b000, e.te});
            check({e.tag, " last_owner"},  {2'b00, last_owner},   {2'b00, e.lo});
        end
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //                   tag        rst req     rdy  grant   sel te lo
        // single requester, ready in the third grant cycle
        vecs.push_back(mk("rst0",     0, 4'b0000, 0, 4'b0000, 0, 0, 3));
        vecs.push_back(mk("single1",  1, 4'b0001, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk("single2",  1, 4'b0001, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk("single3",  1, 4'b0001, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk("single4",  1, 4'b0001, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk("single5",  1, 4'b0000, 0, 4'b0000, 0, 0, 0));
        // all four requesting: order 0,1,2,3 back-to-back
        vecs.push_back(mk("rst1",     0, 4'b0000, 0, 4'b0000, 0, 0, 3));
        vecs.push_back(mk("all_a",    1, 4'b1111, 0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk("all_b",    1, 4'b1111, 1, 4'b0010, 1, 0, 0));
        vecs.push_back(mk("all_c",    1, 4'b1110, 1, 4'b0100, 2, 0, 1));
        vecs.push_back(mk("all_d",    1, 4'b1100, 1, 4'b1000, 3, 0, 2));
        vecs.push_back(mk("all_e",    1, 4'b1000, 1, 4'b0000, 3, 0, 3));
        vecs.push_back(mk("all_f",    1, 4'b0000, 0, 4'b0000, 3, 0, 3));
        // bring pointer to 2, then 0101 arrives: 0 wins, then 2
        vecs.push_back(mk("ptr_a",    1, 4'b0100, 0, 4'b0100, 2, 0, 3));
        vecs.push_back(mk("ptr_b",    1, 4'b0100, 1, 4'b0000, 2, 0, 2));
        vecs.push_back(mk("ptr_c",    1, 4'b0101, 0, 4'b0001, 0, 0, 2));
        vecs.push_back(mk("ptr_d",    1, 4'b0101, 1, 4'b0100, 2, 0, 0));
        vecs.push_back(mk("ptr_e",    1, 4'b0100, 1, 4'b0000, 2, 0, 2));
        vecs.push_back(mk("ptr_f",    1, 4'b0000, 0, 4'b0000, 2, 0, 2));
        // watchdog: grant held exactly 4 cycles, then a one-cycle error pulse
        vecs.push_back(mk("to_a",     1, 4'b0010, 0, 4'b0010, 1, 0, 2));
        vecs.push_back(mk("to_b",     1, 4'b0010, 0, 4'b0010, 1, 0, 2));
        vecs.push_back(mk("to_c",     1, 4'b0010, 0, 4'b0010, 1, 0, 2));
        vecs.push_back(mk("to_d",     1, 4'b0010, 0, 4'b0010, 1, 0, 2));
        vecs.push_back(mk("to_e",     1, 4'b0010, 0, 4'b0000, 1, 1, 1));
        vecs.push_back(mk("to_f",     1, 4'b0000, 0, 4'b0000, 1, 0, 1));
        // ready in the 4th grant cycle is a normal completion
        vecs.push_back(mk("edge_a",   1, 4'b1000, 0, 4'b1000, 3, 0, 1));
        vecs.push_back(mk("edge_b",   1, 4'b1000, 0, 4'b1000, 3, 0, 1));
        vecs.push_back(mk("edge_c",   1, 4'b1000, 0, 4'b1000, 3, 0, 1));
        vecs.push_back(mk("edge_d",   1, 4'b1000, 0, 4'b1000, 3, 0, 1));
        vecs.push_back(mk("edge_e",   1, 4'b1000, 1, 4'b0000, 3, 0, 3));
        vecs.push_back(mk("edge_f",   1, 4'b0000, 0, 4'b0000, 3, 0, 3));
        // reset while owner 3 is busy, then re-grant to 3 from search 0..3
        vecs.push_back(mk("mrst_a",   1, 4'b1000, 0, 4'b1000, 3, 0, 3));
        vecs.push_back(mk("mrst_b",   0, 4'b1000, 0, 4'b0000, 0, 0, 3));
        vecs.push_back(mk("mrst_c",   1, 4'b1000, 0, 4'b1000, 3, 0, 3));
        vecs.push_back(mk("mrst_d",   1, 4'b1000, 1, 4'b0000, 3, 0, 3));
        // ready while idle is ignored
        vecs.push_back(mk("idle_rdy", 1, 4'b0000, 1, 4'b0000, 3, 0, 3));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Hand sequence: dropping req while granted does not release the grant.
        step(mk("drop_a", 1, 4'b0001, 0, 4'b0001, 0, 0, 3));
        step(mk("drop_b", 1, 4'b0000, 0, 4'b0001, 0, 0, 3));
        step(mk("drop_c", 1, 4'b0000, 0, 4'b0001, 0, 0, 3));
        step(mk("drop_d", 1, 4'b0000, 1, 4'b0000, 0, 0, 0));

        // Hand sequence: watchdog release hands straight over to a waiter.
        step(mk("tow_a",  1, 4'b0110, 0, 4'b0010, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            step(mk("tow_hold", 1, 4'b0110, 0, 4'b0010, 1, 0, 0));
        step(mk("tow_b",  1, 4'b0110, 0, 4'b0100, 2, 1, 1));
        step(mk("tow_c",  1, 4'b0100, 1, 4'b0000, 2, 0, 2));
        step(mk("tow_d",  1, 4'b0000, 0, 4'b0000, 2, 0, 2));

        // Let the monitor drain the queue, bounded in cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 4'(sb.size()), 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
